lcd8080_target: RTL and testbench

Bus-target (panel-side) end of the 8-bit 8080-style LCD interface that the Nios II LCD controller drives (CS_n, RS, WR_n, RD_n, DATA[7:0]). It samples the asynchronous bus in the fabric clock domain and decodes the ILI93xx-style command set. RAMWR byte pairs become addressed RGB565 pixel writes on a valid/ready stream, and read-ID requests are answered on the bus. It serves as an in-FPGA display sink and as the bench responder for the LCD controller.

---
 rtl/lcd8080_pkg.sv | 26 ++
 rtl/lcd8080_pix_fifo.sv | 50 +++++
 rtl/lcd8080_target.sv | 275 +++++++++++++++++++++++++++
 tb/tb_lcd8080_target.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd8080_pkg.sv
// Shared definitions for the 8080-bus LCD target: command codes, decoder
// states and the byte-pair helper used for both window parameters and pixels.
package lcd8080_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_RDDID   = 8'h04;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int PIX_DATA_W  = 16;
    localparam int PARAM_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_RDDID
    } state_e;

    function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/lcd8080_pix_fifo.sv
// Small show-ahead FIFO for completed pixels; head entry is visible while not
// empty and reads as zero when empty.
module lcd8080_pix_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is still taken when the head leaves this cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lcd8080_target.sv
// Panel-side 8080 bus target: synchronizes the bus, decodes the ILI93xx-style
// command subset, streams RAMWR pixels and answers RDDID reads.
module lcd8080_target
    import lcd8080_pkg::*;
#(
    parameter int          H_RES      = 480,
    parameter int          V_RES      = 272,
    parameter int          X_W        = 9,
    parameter int          Y_W        = 9,
    parameter logic [23:0] PANEL_ID   = 24'h009341,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           lcd_cs_n_i,
    input  logic           lcd_rs_i,
    input  logic           lcd_wr_n_i,
    input  logic           lcd_rd_n_i,
    input  logic [7:0]     lcd_data_in_i,
    output logic [7:0]     lcd_data_out_o,
    output logic           lcd_data_oe_o,
    output logic           pix_valid_o,
    input  logic           pix_ready_i,
    output logic [X_W-1:0] pix_x_o,
    output logic [Y_W-1:0] pix_y_o,
    output logic [15:0]    pix_data_o,
    output logic           cmd_strobe_o,
    output logic [7:0]     cmd_code_o,
    output logic           overflow_o
);
    localparam int             PW     = X_W + Y_W + PIX_DATA_W;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    // Bus bundle {cs_n, rs, wr_n, rd_n, data}; flops clear to 0 so a strobe
    // needs a falling edge seen after reset before its rising edge counts.
    logic [11:0] bus_raw, sync1_q, sync2_q;
    assign bus_raw = {lcd_cs_n_i, lcd_rs_i, lcd_wr_n_i, lcd_rd_n_i, lcd_data_in_i};

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_sync
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    sync1_q[gi] <= 1'b0;
                    sync2_q[gi] <= 1'b0;
                end else begin
                    sync1_q[gi] <= bus_raw[gi];
                    sync2_q[gi] <= sync1_q[gi];
                end
            end
        end
    endgenerate

    logic       cs_s, rs_s, wr_s, rd_s;
    logic [7:0] d_s;
    assign {cs_s, rs_s, wr_s, rd_s, d_s} = sync2_q;

    logic wr_prev_q, rd_prev_q, wr_arm_q, rd_arm_q, wr_arm_d, rd_arm_d;
    logic wr_fall, wr_rise, rd_fall, rd_up;
    assign wr_fall = wr_prev_q & ~wr_s & ~cs_s;
    assign wr_rise = ~wr_prev_q & wr_s & ~cs_s & wr_arm_q;
    assign rd_fall = rd_prev_q & ~rd_s & ~cs_s;
    assign rd_up   = ~rd_prev_q & rd_s;

    state_e               state_q, state_d;
    logic [2:0]           pidx_q, pidx_d, rd_ptr_q, rd_ptr_d;
    logic [2:0][7:0]      param_q, param_d;
    logic [X_W-1:0]       sc_q, sc_d, ec_q, ec_d, cur_x_q, cur_x_d, x_first, x_last;
    logic [Y_W-1:0]       sp_q, sp_d, ep_q, ep_d, cur_y_q, cur_y_d, y_first, y_last;
    logic                 hi_phase_q, hi_phase_d, push_q, push_d;
    logic [7:0]           hi_byte_q, hi_byte_d, cmd_code_q, cmd_code_d;
    logic [7:0]           data_out_q, data_out_d, rd_byte;
    logic [PW-1:0]        push_word_q, push_word_d, fifo_dout;
    logic                 cmd_strobe_q, cmd_strobe_d, overflow_q, overflow_d;
    logic                 oe_q, oe_d, fifo_full, fifo_empty, pop, ovf_drop;
    logic [15:0]          first_w, last_w;

    assign first_w = be16(param_q[0], param_q[1]);
    assign last_w  = be16(param_q[2], d_s);
    assign x_first = first_w[X_W-1:0];
    assign x_last  = last_w[X_W-1:0];
    assign y_first = first_w[Y_W-1:0];
    assign y_last  = last_w[Y_W-1:0];

    assign pop      = ~fifo_empty & pix_ready_i;
    assign ovf_drop = push_q & fifo_full & ~pop;

    always_comb begin
        rd_byte = 8'h00;
        if (state_q == ST_RDDID) begin
            case (rd_ptr_q)
                3'd1:    rd_byte = PANEL_ID[23:16];
                3'd2:    rd_byte = PANEL_ID[15:8];
                3'd3:    rd_byte = PANEL_ID[7:0];
                default: rd_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        pidx_d       = pidx_q;
        param_d      = param_q;
        sc_d         = sc_q;
        ec_d         = ec_q;
        sp_d         = sp_q;
        ep_d         = ep_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        hi_phase_d   = hi_phase_q;
        hi_byte_d    = hi_byte_q;
        push_d       = 1'b0;
        push_word_d  = push_word_q;
        cmd_strobe_d = 1'b0;
        cmd_code_d   = cmd_code_q;
        overflow_d   = overflow_q | ovf_drop;
        rd_ptr_d     = rd_ptr_q;
        data_out_d   = data_out_q;
        oe_d         = oe_q;
        wr_arm_d     = wr_arm_q;
        rd_arm_d     = rd_arm_q;

        if (wr_fall) wr_arm_d = 1'b1;
        else if (wr_s && !wr_prev_q) wr_arm_d = 1'b0;

        if (rd_fall) begin
            rd_arm_d   = 1'b1;
            data_out_d = rd_byte;
            oe_d       = 1'b1;
        end else if (rd_s || cs_s) begin
            oe_d = 1'b0;
        end
        if (rd_up && rd_arm_q) begin
            rd_arm_d = 1'b0;
            if (rd_ptr_q != 3'd4) rd_ptr_d = rd_ptr_q + 3'd1;
        end

        if (wr_rise && !rs_s) begin
            cmd_strobe_d = 1'b1;
            cmd_code_d   = d_s;
            pidx_d       = '0;
            hi_phase_d   = 1'b1;
            case (d_s)
                CMD_CASET: state_d = ST_CASET;
                CMD_PASET: state_d = ST_PASET;
                CMD_RAMWR: begin
                    state_d = ST_RAMWR;
                    cur_x_d = sc_q;
                    cur_y_d = sp_q;
                end
                CMD_RDDID: begin
                    state_d  = ST_RDDID;
                    rd_ptr_d = '0;
                end
                CMD_SWRESET: begin
                    state_d    = ST_IDLE;
                    sc_d       = '0;
                    ec_d       = X_LAST;
                    sp_d       = '0;
                    ep_d       = Y_LAST;
                    overflow_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (wr_rise) begin
            case (state_q)
                ST_CASET, ST_PASET: begin
                    if (pidx_q < 3'(PARAM_BYTES)) begin
                        pidx_d = pidx_q + 3'd1;
                        if (pidx_q < 3'd3) param_d[pidx_q[1:0]] = d_s;
                    end
                    if (pidx_q == 3'd3 && state_q == ST_CASET) begin
                        sc_d = x_first;
                        ec_d = (x_last < x_first) ? x_first : x_last;
                    end else if (pidx_q == 3'd3) begin
                        sp_d = y_first;
                        ep_d = (y_last < y_first) ? y_first : y_last;
                    end
                end
                ST_RAMWR: begin
                    if (hi_phase_q) begin
                        hi_byte_d  = d_s;
                        hi_phase_d = 1'b0;
                    end else begin
                        hi_phase_d  = 1'b1;
                        push_d      = 1'b1;
                        push_word_d = {cur_x_q, cur_y_q, be16(hi_byte_q, d_s)};
                        if (cur_x_q == ec_q) begin
                            cur_x_d = sc_q;
                            cur_y_d = (cur_y_q == ep_q) ? sp_q : cur_y_q + 1'b1;
                        end else begin
                            cur_x_d = cur_x_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_prev_q    <= 1'b0;
            rd_prev_q    <= 1'b0;
            wr_arm_q     <= 1'b0;
            rd_arm_q     <= 1'b0;
            state_q      <= ST_IDLE;
            pidx_q       <= '0;
            param_q      <= '0;
            sc_q         <= '0;
            ec_q         <= X_LAST;
            sp_q         <= '0;
            ep_q         <= Y_LAST;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            hi_phase_q   <= 1'b1;
            hi_byte_q    <= '0;
            push_q       <= 1'b0;
            push_word_q  <= '0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= '0;
            overflow_q   <= 1'b0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            oe_q         <= 1'b0;
        end else begin
            wr_prev_q    <= wr_s;
            rd_prev_q    <= rd_s;
            wr_arm_q     <= wr_arm_d;
            rd_arm_q     <= rd_arm_d;
            state_q      <= state_d;
            pidx_q       <= pidx_d;
            param_q      <= param_d;
            sc_q         <= sc_d;
            ec_q         <= ec_d;
            sp_q         <= sp_d;
            ep_q         <= ep_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            hi_phase_q   <= hi_phase_d;
            hi_byte_q    <= hi_byte_d;
            push_q       <= push_d;
            push_word_q  <= push_word_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_code_q   <= cmd_code_d;
            overflow_q   <= overflow_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            oe_q         <= oe_d;
        end
    end

    lcd8080_pix_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .push_i  (push_q),
        .din_i   (push_word_q),
        .pop_i   (pix_ready_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {pix_x_o, pix_y_o, pix_data_o} = fifo_dout;
    assign pix_valid_o    = ~fifo_empty;
    assign cmd_strobe_o   = cmd_strobe_q;
    assign cmd_code_o     = cmd_code_q;
    assign overflow_o     = overflow_q;
    assign lcd_data_out_o = data_out_q;
    assign lcd_data_oe_o  = oe_q;

endmodule

// File: tb/tb_lcd8080_target.sv
// Directed bench for lcd8080_target: table of bus writes with expected strobes
// and pixels, plus hand sequences for backpressure, RDDID reads and reset.
module tb_lcd8080_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n, rs, wr_n, rd_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe, pv, pr, stb, ovf;
    logic [8:0] px, py;
    logic [15:0] pd;
    logic [7:0] code;

    always #10 clk = ~clk;

    lcd8080_target dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .lcd_cs_n_i     (cs_n),
        .lcd_rs_i       (rs),
        .lcd_wr_n_i     (wr_n),
        .lcd_rd_n_i     (rd_n),
        .lcd_data_in_i  (din),
        .lcd_data_out_o (dout),
        .lcd_data_oe_o  (oe),
        .pix_valid_o    (pv),
        .pix_ready_i    (pr),
        .pix_x_o        (px),
        .pix_y_o        (py),
        .pix_data_o     (pd),
        .cmd_strobe_o   (stb),
        .cmd_code_o     (code),
        .overflow_o     (ovf)
    );

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } pix_t;

    typedef struct {
        logic        rs;
        logic [7:0]  d;
        int          n_stb;
        logic [7:0]  code;
        int          n_pix;
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] data;
    } vec_t;

    pix_t pq[$];
    vec_t tbl[$];
    int   n_strobe = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] cur_code = 8'h00;

    // Observe outputs on the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (stb) n_strobe++;
            if (pv && pr) pq.push_back('{px, py, pd});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic r, input logic [7:0] d);
        cs_n = 1'b0; rs = r; din = d; wr_n = 1'b0;
        repeat (4) step();
        wr_n = 1'b1;
        repeat (6) step();
        cs_n = 1'b1;
        step();
    endtask

    task automatic bus_rd(output logic [7:0] d, output logic oe_lo, output logic oe_hi);
        cs_n = 1'b0; rd_n = 1'b0;
        repeat (5) step();
        d = dout; oe_lo = oe;
        rd_n = 1'b1;
        repeat (4) step();
        oe_hi = oe;
        cs_n = 1'b1;
        step();
    endtask

    task automatic add_cmd(input logic [7:0] c);
        cur_code = c;
        tbl.push_back('{1'b0, c, 1, c, 0, 9'd0, 9'd0, 16'd0});
    endtask

    task automatic add_dat(input logic [7:0] d);
        tbl.push_back('{1'b1, d, 0, cur_code, 0, 9'd0, 9'd0, 16'd0});
    endtask

    task automatic add_pix(input logic [15:0] v, input int x, input int y);
        add_dat(v[15:8]);
        tbl.push_back('{1'b1, v[7:0], 0, cur_code, 1, 9'(x), 9'(y), v});
    endtask

    int s0, p0;
    logic [7:0] rdat;
    logic oel, oeh;
    logic [7:0] id_exp [5];

    initial begin
        // Window 10..12 x 5..6, then 7 pixels to show the wrap back to (10,5).
        add_cmd(8'h2A); add_dat(8'h00); add_dat(8'h0A); add_dat(8'h00); add_dat(8'h0C);
        add_cmd(8'h2B); add_dat(8'h00); add_dat(8'h05); add_dat(8'h00); add_dat(8'h06);
        add_cmd(8'h2C);
        add_pix(16'hF800, 10, 5); add_pix(16'hF800, 11, 5); add_pix(16'hF800, 12, 5);
        add_pix(16'hF800, 10, 6); add_pix(16'hF800, 11, 6); add_pix(16'hF800, 12, 6);
        add_pix(16'hF800, 10, 5);
        // End column below start column collapses to a single column.
        add_cmd(8'h2A); add_dat(8'h00); add_dat(8'h08); add_dat(8'h00); add_dat(8'h03);
        add_cmd(8'h2C);
        add_pix(16'h001F, 8, 5); add_pix(16'h07E0, 8, 6); add_pix(16'h1234, 8, 5);
        // Unknown command after a lone high byte drops it; data then ignored.
        add_cmd(8'h2C); add_dat(8'hF8); add_cmd(8'h36); add_dat(8'h00); add_dat(8'h1F);

        rst = 1'b1; cs_n = 1'b1; rs = 1'b0; wr_n = 1'b1; rd_n = 1'b1; din = 8'h00; pr = 1'b1;
        repeat (3) step();
        chk("rst pix_valid", 32'(pv), 0);
        chk("rst pix_x", 32'(px), 0);
        chk("rst pix_data", 32'(pd), 0);
        chk("rst cmd_code", 32'(code), 0);
        chk("rst overflow", 32'(ovf), 0);
        chk("rst data_oe", 32'(oe), 0);
        chk("rst data_out", 32'(dout), 0);
        rst = 1'b0;
        repeat (4) step();
        chk("idle strobes", 32'(n_strobe), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            s0 = n_strobe;
            p0 = pq.size();
            bus_wr(tbl[i].rs, tbl[i].d);
            chk($sformatf("v%0d strobes", i), 32'(n_strobe - s0), 32'(tbl[i].n_stb));
            chk($sformatf("v%0d cmd_code", i), 32'(code), 32'(tbl[i].code));
            chk($sformatf("v%0d pixels", i), 32'(pq.size() - p0), 32'(tbl[i].n_pix));
            if (tbl[i].n_pix == 1 && pq.size() > p0) begin
                chk($sformatf("v%0d pix_x", i), 32'(pq[p0].x), 32'(tbl[i].x));
                chk($sformatf("v%0d pix_y", i), 32'(pq[p0].y), 32'(tbl[i].y));
                chk($sformatf("v%0d pix_data", i), 32'(pq[p0].d), 32'(tbl[i].data));
            end
        end

        // Backpressure: four pixels held, the fifth and sixth are dropped.
        bus_wr(1'b0, 8'h01);
        chk("swreset overflow", 32'(ovf), 0);
        pr = 1'b0;
        bus_wr(1'b0, 8'h2C);
        for (int i = 0; i < 6; i++) begin
            bus_wr(1'b1, 8'(8'h10 + i));
            bus_wr(1'b1, 8'(8'h20 + i));
            chk($sformatf("bp%0d overflow", i), 32'(ovf), (i >= 4) ? 1 : 0);
        end
        chk("bp held valid", 32'(pv), 1);
        chk("bp held x", 32'(px), 0);
        chk("bp held data", 32'(pd), 32'h1020);
        p0 = pq.size();
        pr = 1'b1;
        repeat (12) step();
        pr = 1'b0;
        chk("bp drained count", 32'(pq.size() - p0), 4);
        for (int k = 0; k < 4 && p0 + k < pq.size(); k++) begin
            chk($sformatf("bp out%0d x", k), 32'(pq[p0+k].x), 32'(k));
            chk($sformatf("bp out%0d data", k), 32'(pq[p0+k].d), 32'({8'(8'h10 + k), 8'(8'h20 + k)}));
        end
        chk("bp empty after", 32'(pv), 0);
        bus_wr(1'b0, 8'h01);
        chk("swreset clears overflow", 32'(ovf), 0);

        // RDDID: dummy, ID bytes, then zeros.
        id_exp = '{8'h00, 8'h00, 8'h93, 8'h41, 8'h00};
        bus_wr(1'b0, 8'h04);
        chk("rd oe idle", 32'(oe), 0);
        for (int i = 0; i < 5; i++) begin
            bus_rd(rdat, oel, oeh);
            chk($sformatf("rd%0d data", i), 32'(rdat), 32'(id_exp[i]));
            chk($sformatf("rd%0d oe low", i), 32'(oel), 1);
            chk($sformatf("rd%0d oe high", i), 32'(oeh), 0);
        end

        // Reset with WR held low mid-RAMWR and a pixel sitting in the FIFO.
        bus_wr(1'b0, 8'h2C);
        bus_wr(1'b1, 8'hAB);
        bus_wr(1'b1, 8'hCD);
        chk("pre-rst valid", 32'(pv), 1);
        chk("pre-rst data", 32'(pd), 32'hABCD);
        cs_n = 1'b0; rs = 1'b1; din = 8'h55; wr_n = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        repeat (2) step();
        chk("mid-rst valid", 32'(pv), 0);
        chk("mid-rst pix_data", 32'(pd), 0);
        chk("mid-rst cmd_code", 32'(code), 0);
        chk("mid-rst strobe", 32'(stb), 0);
        chk("mid-rst oe", 32'(oe), 0);
        rst = 1'b0;
        repeat (5) step();
        s0 = n_strobe;
        p0 = pq.size();
        pr = 1'b1;
        wr_n = 1'b1;
        repeat (8) step();
        cs_n = 1'b1;
        step();
        chk("post-rst strobes", 32'(n_strobe - s0), 0);
        chk("post-rst pixels", 32'(pq.size() - p0), 0);
        chk("post-rst valid", 32'(pv), 0);
        bus_wr(1'b0, 8'h36);
        chk("recover strobes", 32'(n_strobe - s0), 1);
        chk("recover code", 32'(code), 32'h36);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
